apb_master_arb: RTL and testbench



---
 rtl/apb_master_arb.sv | 217 +++++++++++++++++++++
 tb/tb_apb_master_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb
// ---------------------------------------------------------------------------
// Two-requester APB master sharing one APB bus among up to four register
// slaves (four 32-bit registers each, selected by PADDR[3:2]). Requests are
// arbitrated round-robin. The target slave is decoded from addr[5:4]. The
// block sequences the SETUP/ACCESS phases, aborts an ACCESS that waits too
// long for PREADY, and returns read data or an error to the granted
// requester as a one-cycle rsp_valid pulse.
//
// Ports
//   PCLK, PRESET             clock, asynchronous active-high reset
//   req_valid[1:0]           request pending per requester
//   req_write[1:0]           1 = write, 0 = read, per requester
//   req0_addr, req1_addr     [7:6] must be 0, [5:4] slave, [3:0] offset
//   req0_wdata, req1_wdata   write data per requester
//   req_ready[1:0]           accept strobe (IDLE only, arbitration winner only)
//   rsp_valid                one-cycle completion pulse
//   rsp_id                   requester owning the response
//   rsp_rdata                read data (0 for writes and errors)
//   rsp_err                  decode error or PREADY timeout
//   busy                     FSM not in IDLE
//   PADDR, PWRITE, PWDATA    APB address/direction/write data
//   PSEL[3:0], PENABLE       APB one-hot select and access phase
//   PRDATA0..PRDATA3         per-slave read data
//   PREADY[3:0]              per-slave ready
// ---------------------------------------------------------------------------
module apb_master_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [7:0]  req0_addr,
    input  logic [7:0]  req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    output logic [1:0]  req_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);

    // Counter wide enough to hold TIMEOUT-1; at least one bit even when the
    // timeout is disabled so the declaration stays legal.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            last_grant;
    logic            id_q;
    logic [1:0]      sel_q;
    logic [CW-1:0]   cnt;

    logic            winner;
    logic            handshake;
    logic [7:0]      win_addr;
    logic            win_write;
    logic [31:0]     win_wdata;
    logic            decode_err;
    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            timeout_hit;

    // Round-robin arbitration: on contention the requester that was not
    // granted last wins; with a single requester it simply wins. The winner
    // also steers which request fields are latched on the handshake.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~last_grant;
        end else if (req_valid[1]) begin
            winner = 1'b1;
        end
        win_addr   = winner ? req1_addr  : req0_addr;
        win_wdata  = winner ? req1_wdata : req0_wdata;
        win_write  = req_write[winner];
        decode_err = (win_addr[7:6] != 2'b00);
        handshake  = (state == ST_IDLE) && (req_valid != 2'b00);
    end

    // Only the selected slave's PREADY/PRDATA matter; the rest are ignored.
    // The timeout fires in the last allowed ACCESS cycle only when PREADY is
    // still low, so a late PREADY in that same cycle still counts as success.
    always_comb begin
        sel_ready = PREADY[sel_q];
        case (sel_q)
            2'd0:    sel_rdata = PRDATA0;
            2'd1:    sel_rdata = PRDATA1;
            2'd2:    sel_rdata = PRDATA2;
            default: sel_rdata = PRDATA3;
        endcase
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !sel_ready;
    end

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and bus control. PSEL is derived from the state so it
    // rises in SETUP, one cycle ahead of PENABLE, and both fall together
    // on completion, timeout or reset.
    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        PSEL       = 4'b0000;
        PENABLE    = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready = winner ? 2'b10 : 2'b01;
                    if (!decode_err) begin
                        next_state = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                PSEL[sel_q] = 1'b1;
                next_state  = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL[sel_q] = 1'b1;
                PENABLE     = 1'b1;
                if (sel_ready || timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, arbitration pointer, timeout counter and response
    // registers. The APB address/data only update on a handshake that will
    // actually use the bus, so a decode error leaves the bus untouched and
    // the last transfer's values stay visible.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            sel_q      <= 2'd0;
            cnt        <= '0;
            PADDR      <= 4'h0;
            PWRITE     <= 1'b0;
            PWDATA     <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (handshake) begin
                last_grant <= winner;
                id_q       <= winner;
                if (decode_err) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_id    <= winner;
                end else begin
                    PADDR  <= win_addr[3:0];
                    PWRITE <= win_write;
                    PWDATA <= win_wdata;
                    sel_q  <= win_addr[5:4];
                end
            end

            if (state == ST_ACCESS) begin
                if (sel_ready) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_id    <= id_q;
                    rsp_rdata <= PWRITE ? 32'h0 : sel_rdata;
                    cnt       <= '0;
                end else if (timeout_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_rdata <= 32'h0;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb
// ---------------------------------------------------------------------------
// Self-checking bench for apb_master_arb. Four behavioural register slaves
// with programmable wait states (or no PREADY at all) sit on the APB side.
// A directed vector table covers the documented scenarios, hand-written
// sequences cover contention and reset during ACCESS, and a randomized
// phase is checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_apb_master_arb;

    localparam int TIMEOUT = 16;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req0_addr;
    logic [7:0]  req1_addr;
    logic [31:0] req0_wdata;
    logic [31:0] req1_wdata;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic [3:0]  PREADY;

    int errors = 0;
    int checks = 0;

    apb_master_arb #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req0_addr  (req0_addr),
        .req1_addr  (req1_addr),
        .req0_wdata (req0_wdata),
        .req1_wdata (req1_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA0    (PRDATA0),
        .PRDATA1    (PRDATA1),
        .PRDATA2    (PRDATA2),
        .PRDATA3    (PRDATA3),
        .PREADY     (PREADY)
    );

    // Free-running APB clock, 10 time units per cycle.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // ---------------- behavioural slaves ----------------
    logic [31:0] slave_mem [4][4];
    int          waits [4];
    bit          hang [4];
    int          wcnt [4];
    logic        mem_clear;

    // PREADY goes high after the slave's programmed number of wait cycles
    // in ACCESS, or never for a hung slave.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            PREADY[s] = PSEL[s] && PENABLE && !hang[s] && (wcnt[s] >= waits[s]);
        end
    end

    assign PRDATA0 = slave_mem[0][PADDR[3:2]];
    assign PRDATA1 = slave_mem[1][PADDR[3:2]];
    assign PRDATA2 = slave_mem[2][PADDR[3:2]];
    assign PRDATA3 = slave_mem[3][PADDR[3:2]];

    // Slave wait counters and register writes, committed on the ready edge.
    always @(posedge PCLK) begin
        for (int s = 0; s < 4; s++) begin
            if (PSEL[s] && PENABLE && !PREADY[s]) wcnt[s] <= wcnt[s] + 1;
            else                                  wcnt[s] <= 0;
            for (int r = 0; r < 4; r++) begin
                if (mem_clear) slave_mem[s][r] <= 32'h0;
                else if (PSEL[s] && PENABLE && PREADY[s] && PWRITE && (PADDR[3:2] == 2'(r)))
                    slave_mem[s][r] <= PWDATA;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // APB protocol monitor: PENABLE only with PSEL, PSEL one-hot, PSEL
    // established a cycle before PENABLE, and signals stable across a transfer.
    logic [3:0]  prev_psel;
    logic        prev_penable;
    logic [3:0]  prev_paddr;
    logic [31:0] prev_pwdata;
    logic        prev_pwrite;

    always @(negedge PCLK) begin
        if (PRESET) begin
            prev_psel    = 4'h0;
            prev_penable = 1'b0;
        end else begin
            if (PENABLE) checkOutput("apb_penable_needs_psel", 32'(PSEL != 4'h0), 32'd1);
            if (PSEL != 4'h0) checkOutput("apb_psel_onehot", 32'($countones(PSEL)), 32'd1);
            if (PENABLE && !prev_penable) checkOutput("apb_psel_before_penable", 32'(prev_psel), 32'(PSEL));
            if (PSEL != 4'h0 && prev_psel != 4'h0) begin
                checkOutput("apb_stable_psel",   32'(PSEL),   32'(prev_psel));
                checkOutput("apb_stable_paddr",  32'(PADDR),  32'(prev_paddr));
                checkOutput("apb_stable_pwdata", PWDATA,      prev_pwdata);
                checkOutput("apb_stable_pwrite", 32'(PWRITE), 32'(prev_pwrite));
            end
            prev_psel    = PSEL;
            prev_penable = PENABLE;
            prev_paddr   = PADDR;
            prev_pwdata  = PWDATA;
            prev_pwrite  = PWRITE;
        end
    end

    // ---------------- reference model ----------------
    // Expected outcome of a lone request from the documented rules: decode
    // errors answer after one cycle, otherwise latency is 3 plus the slave's
    // wait states unless those reach TIMEOUT, which aborts after TIMEOUT
    // ACCESS cycles.
    logic [31:0] model_mem [4][4];

    task automatic modelPredict(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                                output int lat, output bit err, output logic [31:0] rd,
                                output int bus);
        int s;
        int off;
        s   = int'(addr[5:4]);
        off = int'(addr[3:2]);
        if (addr[7:6] != 2'b00) begin
            lat = 1; err = 1'b1; rd = 32'h0; bus = 0;
        end else if (hang[s] || waits[s] >= TIMEOUT) begin
            lat = TIMEOUT + 2; err = 1'b1; rd = 32'h0; bus = TIMEOUT + 1;
        end else begin
            lat = 3 + waits[s]; err = 1'b0; bus = waits[s] + 2;
            rd  = wr ? 32'h0 : model_mem[s][off];
            if (wr) model_mem[s][off] = wd;
        end
    endtask

    // Issue one request from requester id and observe it to completion.
    task automatic applyStimulus(input int id, input bit wr, input logic [7:0] addr,
                                 input logic [31:0] wd,
                                 output bit ok, output int lat, output logic [31:0] rdata,
                                 output bit err, output bit rid, output logic [3:0] psel_seen,
                                 output logic [3:0] paddr_seen, output int bus_cycles);
        int n;
        ok = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0; rid = 1'b0;
        psel_seen = 4'h0; paddr_seen = 4'h0; bus_cycles = 0;
        req_write[id] = wr;
        if (id == 0) begin req0_addr = addr; req0_wdata = wd; end
        else         begin req1_addr = addr; req1_wdata = wd; end
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 100) begin
            @(negedge PCLK); #1; n++;
        end
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            @(negedge PCLK);
            return;
        end
        @(negedge PCLK);
        req_valid[id] = 1'b0;
        n = 1;
        while (n <= 100) begin
            if (PSEL != 4'h0) begin
                bus_cycles++;
                if (psel_seen == 4'h0) begin psel_seen = PSEL; paddr_seen = PADDR; end
            end
            if (rsp_valid) break;
            @(negedge PCLK);
            n++;
        end
        if (rsp_valid) begin
            ok = 1'b1; lat = n; rdata = rsp_rdata; err = rsp_err; rid = rsp_id;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          id;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          wt;
        bit          hg;
        logic [3:0]  exp_psel;
        logic [3:0]  exp_paddr;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    // Hard limit so a stuck design still reaches a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          ok;
        int          lat;
        logic [31:0] rdata;
        bit          err;
        bit          rid;
        logic [3:0]  psel_seen;
        logic [3:0]  paddr_seen;
        int          bus;
        int          n;
        bit          g;
        bit          seen_rsp;

        vecs[0]  = '{0, 1'b1, 8'h14, 32'hDEADBEEF, 0,  1'b0, 4'b0010, 4'h4, 32'h0,        1'b0, 3};
        vecs[1]  = '{0, 1'b0, 8'h14, 32'h0,        0,  1'b0, 4'b0010, 4'h4, 32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{1, 1'b0, 8'h40, 32'h0,        0,  1'b0, 4'b0000, 4'h0, 32'h0,        1'b1, 1};
        vecs[3]  = '{1, 1'b1, 8'h08, 32'h12345678, 3,  1'b0, 4'b0001, 4'h8, 32'h0,        1'b0, 6};
        vecs[4]  = '{0, 1'b0, 8'h08, 32'h0,        1,  1'b0, 4'b0001, 4'h8, 32'h12345678, 1'b0, 4};
        vecs[5]  = '{0, 1'b0, 8'h20, 32'h0,        0,  1'b1, 4'b0100, 4'h0, 32'h0,        1'b1, 18};
        vecs[6]  = '{1, 1'b1, 8'h2C, 32'hCAFEF00D, 0,  1'b0, 4'b0100, 4'hC, 32'h0,        1'b0, 3};
        vecs[7]  = '{1, 1'b0, 8'h2C, 32'h0,        0,  1'b0, 4'b0100, 4'hC, 32'hCAFEF00D, 1'b0, 3};
        vecs[8]  = '{0, 1'b1, 8'h3C, 32'hA5A5A5A5, 15, 1'b0, 4'b1000, 4'hC, 32'h0,        1'b0, 18};
        vecs[9]  = '{0, 1'b0, 8'h3C, 32'h0,        16, 1'b0, 4'b1000, 4'hC, 32'h0,        1'b1, 18};
        vecs[10] = '{1, 1'b0, 8'h3C, 32'h0,        0,  1'b0, 4'b1000, 4'hC, 32'hA5A5A5A5, 1'b0, 3};
        vecs[11] = '{0, 1'b1, 8'hC4, 32'h11111111, 0,  1'b0, 4'b0000, 4'h0, 32'h0,        1'b1, 1};
        vecs[12] = '{1, 1'b0, 8'h80, 32'h0,        0,  1'b0, 4'b0000, 4'h0, 32'h0,        1'b1, 1};

        for (int s = 0; s < 4; s++) begin
            waits[s] = 0; hang[s] = 1'b0;
            for (int r = 0; r < 4; r++) model_mem[s][r] = 32'h0;
        end
        req_valid = 2'b00; req_write = 2'b00;
        req0_addr = 8'h0; req1_addr = 8'h0; req0_wdata = 32'h0; req1_wdata = 32'h0;
        mem_clear = 1'b1;
        PRESET    = 1'b1;

        // ---- reset state ----
        repeat (3) @(negedge PCLK);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata,      32'h0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_paddr",     32'(PADDR),     32'h0);
        checkOutput("rst_pwrite",    32'(PWRITE),    32'h0);
        checkOutput("rst_pwdata",    PWDATA,         32'h0);
        checkOutput("rst_psel",      32'(PSEL),      32'h0);
        checkOutput("rst_penable",   32'(PENABLE),   32'h0);
        PRESET    = 1'b0;
        mem_clear = 1'b0;
        @(negedge PCLK);

        // ---- contention: both requesters held valid for four transfers ----
        req_write  = 2'b00;
        req0_addr  = 8'h10;
        req1_addr  = 8'h24;
        req_valid  = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin @(negedge PCLK); n++; end
            checkOutput("contention_grant_seen", 32'(req_ready != 2'b00), 32'd1);
            g = req_ready[1];
            checkOutput("contention_grant", 32'(g), 32'(k % 2));
            @(negedge PCLK);
            n = 0;
            while (!rsp_valid && n < 50) begin @(negedge PCLK); n++; end
            checkOutput("contention_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("contention_rsp_id",    32'(rsp_id),    32'(g));
            checkOutput("contention_rsp_err",   32'(rsp_err),   32'd0);
        end
        req_valid = 2'b00;
        @(negedge PCLK);

        // ---- directed vector table ----
        for (int i = 0; i < 13; i++) begin
            waits[int'(vecs[i].addr[5:4])] = vecs[i].wt;
            hang[int'(vecs[i].addr[5:4])]  = vecs[i].hg;
            applyStimulus(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                          ok, lat, rdata, err, rid, psel_seen, paddr_seen, bus);
            checkOutput($sformatf("vec%0d_done", i),  32'(ok),        32'd1);
            checkOutput($sformatf("vec%0d_lat", i),   32'(lat),       32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_err", i),   32'(err),       32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_rdata", i), rdata,          vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_id", i),    32'(rid),       32'(vecs[i].id));
            checkOutput($sformatf("vec%0d_psel", i),  32'(psel_seen), 32'(vecs[i].exp_psel));
            if (vecs[i].exp_psel != 4'h0) begin
                checkOutput($sformatf("vec%0d_paddr", i), 32'(paddr_seen), 32'(vecs[i].exp_paddr));
                checkOutput($sformatf("vec%0d_bus_cycles", i), 32'(bus), 32'(vecs[i].exp_lat - 1));
            end
            hang[int'(vecs[i].addr[5:4])] = 1'b0;
        end
        for (int s = 0; s < 4; s++) waits[s] = 0;

        // ---- reset during ACCESS ----
        waits[3]   = 5;
        req_write  = 2'b10;
        req1_addr  = 8'h30;
        req1_wdata = 32'h55AA55AA;
        req_valid  = 2'b10;
        #1;
        checkOutput("rstseq_grant", 32'(req_ready), 32'h2);
        @(negedge PCLK);
        req_valid = 2'b00;
        repeat (2) @(negedge PCLK);
        checkOutput("rstseq_in_access", 32'(PENABLE), 32'd1);
        checkOutput("rstseq_busy",      32'(busy),    32'd1);
        PRESET = 1'b1;
        #1;
        checkOutput("rstseq_psel",    32'(PSEL),      32'h0);
        checkOutput("rstseq_penable", 32'(PENABLE),   32'h0);
        checkOutput("rstseq_paddr",   32'(PADDR),     32'h0);
        checkOutput("rstseq_pwdata",  PWDATA,         32'h0);
        checkOutput("rstseq_pwrite",  32'(PWRITE),    32'h0);
        checkOutput("rstseq_busy0",   32'(busy),      32'h0);
        checkOutput("rstseq_rsp_id",  32'(rsp_id),    32'h0);
        checkOutput("rstseq_rdata",   rsp_rdata,      32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;
        seen_rsp = 1'b0;
        repeat (8) begin
            @(negedge PCLK);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        checkOutput("rstseq_no_rsp", 32'(seen_rsp), 32'd0);
        req0_addr = 8'h00;
        req1_addr = 8'h00;
        req_valid = 2'b11;
        #1;
        checkOutput("rstseq_first_grant_req0", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        waits[3]  = 0;
        @(negedge PCLK);

        // ---- randomized phase against the reference model ----
        mem_clear = 1'b1;
        @(negedge PCLK);
        mem_clear = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 4; r++) model_mem[s][r] = 32'h0;

        for (int i = 0; i < 60; i++) begin
            int          id;
            bit          wr;
            logic [7:0]  addr;
            logic [31:0] wd;
            int          e_lat;
            bit          e_err;
            logic [31:0] e_rd;
            int          e_bus;
            id = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            addr = 8'($urandom);
            if ($urandom_range(0, 9) != 0) addr[7:6] = 2'b00;
            case ($urandom_range(0, 7))
                0:       waits[int'(addr[5:4])] = TIMEOUT - 1;
                1:       waits[int'(addr[5:4])] = TIMEOUT;
                default: waits[int'(addr[5:4])] = int'($urandom_range(0, 3));
            endcase
            modelPredict(wr, addr, wd, e_lat, e_err, e_rd, e_bus);
            applyStimulus(id, wr, addr, wd, ok, lat, rdata, err, rid, psel_seen, paddr_seen, bus);
            checkOutput("rand_done",  32'(ok),  32'd1);
            checkOutput("rand_lat",   32'(lat), 32'(e_lat));
            checkOutput("rand_err",   32'(err), 32'(e_err));
            checkOutput("rand_rdata", rdata,    e_rd);
            checkOutput("rand_id",    32'(rid), 32'(id));
            checkOutput("rand_bus",   32'(bus), 32'(e_bus));
            if (e_bus != 0) begin
                checkOutput("rand_psel",  32'(psel_seen),  32'(4'b0001 << addr[5:4]));
                checkOutput("rand_paddr", 32'(paddr_seen), 32'(addr[3:0]));
            end
        end

        repeat (2) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
